tri_pixel_collector: RTL and testbench

//  Sink end of the triangle pixel stream: snoops po/xo/yo/busy from the rasteriser and accumulates pixels

---
 rtl/tri_pkg.sv | 15 +
 rtl/tri_bbox_acc.sv | 59 +++++
 rtl/tri_pixel_collector.sv | 145 ++++++++++++++
 tb/tb_tri_pixel_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared sizing defaults and controller state encoding for the triangle pixel collector.
package tri_pkg;

    localparam int COORD_W = 3;
    localparam int GRID    = 1 << COORD_W;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2,
        CLEAR   = 2'd3
    } state_e;

endpackage

// File: rtl/tri_bbox_acc.sv
// Bounding-box accumulator: init seeds the box with one point, upd widens it to cover another.
module tri_bbox_acc
#(
    parameter int COORD_W = tri_pkg::COORD_W
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               init_i,
    input  logic               upd_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [COORD_W-1:0] xMin_o,
    output logic [COORD_W-1:0] xMax_o,
    output logic [COORD_W-1:0] yMin_o,
    output logic [COORD_W-1:0] yMax_o
);

    logic [COORD_W-1:0] xMin_q, xMax_q, yMin_q, yMax_q;
    logic [COORD_W-1:0] xMin_d, xMax_d, yMin_d, yMax_d;

    always_comb begin
        xMin_d = xMin_q;
        xMax_d = xMax_q;
        yMin_d = yMin_q;
        yMax_d = yMax_q;
        if (init_i) begin
            xMin_d = x_i;
            xMax_d = x_i;
            yMin_d = y_i;
            yMax_d = y_i;
        end else if (upd_i) begin
            if (x_i < xMin_q) xMin_d = x_i;
            if (x_i > xMax_q) xMax_d = x_i;
            if (y_i < yMin_q) yMin_d = y_i;
            if (y_i > yMax_q) yMax_d = y_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xMin_q <= '0;
            xMax_q <= '0;
            yMin_q <= '0;
            yMax_q <= '0;
        end else begin
            xMin_q <= xMin_d;
            xMax_q <= xMax_d;
            yMin_q <= yMin_d;
            yMax_q <= yMax_d;
        end
    end

    assign xMin_o = xMin_q;
    assign xMax_o = xMax_q;
    assign yMin_o = yMin_q;
    assign yMax_o = yMax_q;

endmodule

// File: rtl/tri_pixel_collector.sv
// Sink for the rasteriser pixel stream: accumulates pixels into a 1-bit frame buffer
// and reports per-triangle pixel/overlap counts and bounding box.
module tri_pixel_collector
#(
    parameter int COORD_W = tri_pkg::COORD_W,
    parameter int CNT_W   = tri_pkg::CNT_W
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     po,
    input  logic [COORD_W-1:0]       xo,
    input  logic [COORD_W-1:0]       yo,
    input  logic                     busy,
    input  logic                     clr,
    input  logic [COORD_W-1:0]       rd_row,
    output logic [(1<<COORD_W)-1:0]  rd_data,
    output logic                     collecting,
    output logic                     clr_busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pix_cnt,
    output logic [CNT_W-1:0]         dup_cnt,
    output logic [COORD_W-1:0]       xmin,
    output logic [COORD_W-1:0]       xmax,
    output logic [COORD_W-1:0]       ymin,
    output logic [COORD_W-1:0]       ymax
);

    import tri_pkg::*;

    localparam int              GRID_L  = 1 << COORD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q;
    logic [GRID_L-1:0]  fb_q [GRID_L];
    logic [GRID_L-1:0]  fbRow_d [GRID_L];
    logic [CNT_W-1:0]   pixCnt_q, dupCnt_q;
    logic [CNT_W-1:0]   pixInc, dupInc;
    logic               clrPend_q;
    logic [COORD_W-1:0] rowCtr_q;

    logic               wrEn;
    logic               hit;
    logic               bboxInit, bboxUpd;
    logic [GRID_L-1:0]  colOh, wrRowOh, clrRowOh;

    // Pixels are only accepted while a triangle can start or is in progress.
    assign wrEn     = po && (state_q == IDLE || state_q == COLLECT);
    assign hit      = fb_q[yo][xo];
    assign colOh    = GRID_L'(1) << xo;
    assign wrRowOh  = wrEn ? (GRID_L'(1) << yo) : '0;
    assign clrRowOh = (state_q == CLEAR) ? (GRID_L'(1) << rowCtr_q) : '0;
    assign bboxInit = po && (state_q == IDLE);
    assign bboxUpd  = po && (state_q == COLLECT);

    assign pixInc = (pixCnt_q == CNT_MAX) ? pixCnt_q : pixCnt_q + 1'b1;
    assign dupInc = (dupCnt_q == CNT_MAX) ? dupCnt_q : dupCnt_q + 1'b1;

    always_comb begin
        for (int r = 0; r < GRID_L; r++) begin
            fbRow_d[r] = fb_q[r];
            if (clrRowOh[r])
                fbRow_d[r] = '0;
            else if (wrRowOh[r])
                fbRow_d[r] = fb_q[r] | colOh;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < GRID_L; r++) begin
            if (reset)
                fb_q[r] <= '0;
            else
                fb_q[r] <= fbRow_d[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pixCnt_q  <= '0;
            dupCnt_q  <= '0;
            clrPend_q <= 1'b0;
            rowCtr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (po) begin
                        pixCnt_q  <= CNT_W'(1);
                        dupCnt_q  <= CNT_W'(hit);
                        clrPend_q <= clr;
                        state_q   <= COLLECT;
                    end else if (clr || clrPend_q) begin
                        rowCtr_q  <= '0;
                        clrPend_q <= 1'b0;
                        state_q   <= CLEAR;
                    end
                end
                COLLECT: begin
                    if (po) begin
                        pixCnt_q <= pixInc;
                        if (hit) dupCnt_q <= dupInc;
                    end
                    if (clr) clrPend_q <= 1'b1;
                    if (!busy) state_q <= REPORT;
                end
                REPORT: begin
                    if (clrPend_q || clr) begin
                        rowCtr_q  <= '0;
                        clrPend_q <= 1'b0;
                        state_q   <= CLEAR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CLEAR: begin
                    rowCtr_q <= rowCtr_q + 1'b1;
                    if (rowCtr_q == COORD_W'(GRID_L - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tri_bbox_acc #(.COORD_W(COORD_W)) uBbox (
        .clk    (clk),
        .reset  (reset),
        .init_i (bboxInit),
        .upd_i  (bboxUpd),
        .x_i    (xo),
        .y_i    (yo),
        .xMin_o (xmin),
        .xMax_o (xmax),
        .yMin_o (ymin),
        .yMax_o (ymax)
    );

    assign rd_data    = fb_q[rd_row];
    assign collecting = (state_q == COLLECT);
    assign clr_busy   = (state_q == CLEAR);
    assign done       = (state_q == REPORT);
    assign pix_cnt    = pixCnt_q;
    assign dup_cnt    = dupCnt_q;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed bench for tri_pixel_collector: triangles, overlap, clears and mid-triangle reset.
module tb_tri_pixel_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       po;
    logic [2:0] xo, yo;
    logic       busy;
    logic       clr;
    logic [2:0] rd_row;
    logic [7:0] rd_data;
    logic       collecting, clr_busy, done;
    logic [6:0] pix_cnt, dup_cnt;
    logic [2:0] xmin, xmax, ymin, ymax;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    tri_pixel_collector dut (
        .clk        (clk),
        .reset      (reset),
        .po         (po),
        .xo         (xo),
        .yo         (yo),
        .busy       (busy),
        .clr        (clr),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .collecting (collecting),
        .clr_busy   (clr_busy),
        .done       (done),
        .pix_cnt    (pix_cnt),
        .dup_cnt    (dup_cnt),
        .xmin       (xmin),
        .xmax       (xmax),
        .ymin       (ymin),
        .ymax       (ymax)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic p, input logic [2:0] x, input logic [2:0] y,
                                 input logic b, input logic c);
        po   = p;
        xo   = x;
        yo   = y;
        busy = b;
        clr  = c;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRow(input string tag, input logic [2:0] r, input logic [7:0] expected);
        rd_row = r;
        #1;
        checkOutput(tag, 32'(rd_data), 32'(expected));
    endtask

    task automatic checkAllRowsZero(input string tag);
        for (int r = 0; r < 8; r++) checkRow(tag, 3'(r), 8'h00);
    endtask

    // Ticks until clr_busy drops, counting how many sampled cycles showed it high.
    task automatic waitClear(output int cnt);
        cnt = clr_busy ? 1 : 0;
        for (int i = 0; i < 20 && clr_busy; i++) begin
            tick();
            if (clr_busy) cnt++;
        end
    endtask

    task automatic checkSummary(input string tag, input logic [6:0] p, input logic [6:0] d,
                                input logic [2:0] x0, input logic [2:0] x1,
                                input logic [2:0] y0, input logic [2:0] y1);
        checkOutput({tag, "_pix"},  32'(pix_cnt), 32'(p));
        checkOutput({tag, "_dup"},  32'(dup_cnt), 32'(d));
        checkOutput({tag, "_xmin"}, 32'(xmin), 32'(x0));
        checkOutput({tag, "_xmax"}, 32'(xmax), 32'(x1));
        checkOutput({tag, "_ymin"}, 32'(ymin), 32'(y0));
        checkOutput({tag, "_ymax"}, 32'(ymax), 32'(y1));
    endtask

    int clrCycles;

    initial begin
        reset = 1'b1; po = 0; xo = 0; yo = 0; busy = 0; clr = 0; rd_row = 0;
        tick();
        tick();
        checkOutput("rst_collecting", 32'(collecting), 32'd0);
        checkOutput("rst_clr_busy",   32'(clr_busy),   32'd0);
        checkOutput("rst_done",       32'(done),       32'd0);
        checkSummary("rst", 7'd0, 7'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        checkAllRowsZero("rst_fb");
        reset = 1'b0;

        // Triangle 1: (1,1) vertex beat, then (2,1), (1,2).
        applyStimulus(1, 3'd1, 3'd1, 0, 0);
        checkOutput("t1_collecting", 32'(collecting), 32'd1);
        applyStimulus(1, 3'd2, 3'd1, 1, 0);
        applyStimulus(1, 3'd1, 3'd2, 1, 0);
        checkOutput("t1_no_early_done", 32'(done), 32'd0);
        applyStimulus(0, 3'd0, 3'd0, 0, 0);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkSummary("t1", 7'd3, 7'd0, 3'd1, 3'd2, 3'd1, 3'd2);
        checkRow("t1_row1", 3'd1, 8'b0000_0110);
        checkRow("t1_row2", 3'd2, 8'b0000_0010);
        applyStimulus(0, 3'd0, 3'd0, 0, 0);
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_idle", 32'(collecting), 32'd0);

        // Triangle 2 overlaps (2,1); last pixel arrives on the busy-low beat.
        applyStimulus(1, 3'd2, 3'd1, 0, 0);
        applyStimulus(1, 3'd3, 3'd3, 1, 0);
        applyStimulus(1, 3'd4, 3'd3, 1, 0);
        applyStimulus(1, 3'd2, 3'd4, 0, 0);
        checkOutput("t2_done", 32'(done), 32'd1);
        checkSummary("t2", 7'd4, 7'd1, 3'd2, 3'd4, 3'd1, 3'd4);
        checkRow("t2_row1", 3'd1, 8'b0000_0110);
        checkRow("t2_row2", 3'd2, 8'b0000_0010);
        checkRow("t2_row3", 3'd3, 8'b0001_1000);
        checkRow("t2_row4", 3'd4, 8'b0000_0100);
        applyStimulus(0, 3'd0, 3'd0, 0, 0);

        // Clear from IDLE; a pixel offered mid-clear must be dropped.
        applyStimulus(0, 3'd0, 3'd0, 0, 1);
        checkOutput("t3_clr_busy", 32'(clr_busy), 32'd1);
        checkRow("t3_row1_before", 3'd1, 8'b0000_0110);
        po = 1; xo = 3'd6; yo = 3'd7; busy = 0; clr = 0;
        tick();
        po = 0;
        clrCycles = 0;
        waitClear(clrCycles);
        checkOutput("t3_clr_cycles", 32'(clrCycles + 1), 32'd8);
        checkOutput("t3_clr_done", 32'(clr_busy), 32'd0);
        checkOutput("t3_idle", 32'(collecting), 32'd0);
        checkAllRowsZero("t3_fb");
        checkSummary("t3", 7'd4, 7'd1, 3'd2, 3'd4, 3'd1, 3'd4);

        // clr raised mid-triangle is deferred until after the done pulse.
        applyStimulus(1, 3'd5, 3'd5, 0, 0);
        applyStimulus(1, 3'd6, 3'd5, 1, 1);
        applyStimulus(1, 3'd5, 3'd6, 1, 0);
        checkOutput("t4_no_clear", 32'(clr_busy), 32'd0);
        checkRow("t4_row5", 3'd5, 8'b0110_0000);
        applyStimulus(1, 3'd5, 3'd5, 0, 0);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_clr_busy_in_report", 32'(clr_busy), 32'd0);
        checkSummary("t4", 7'd4, 7'd1, 3'd5, 3'd6, 3'd5, 3'd6);
        checkRow("t4_row6", 3'd6, 8'b0010_0000);
        applyStimulus(0, 3'd0, 3'd0, 0, 0);
        checkOutput("t4_clear_start", 32'(clr_busy), 32'd1);
        checkOutput("t4_done_off", 32'(done), 32'd0);
        waitClear(clrCycles);
        checkOutput("t4_clr_cycles", 32'(clrCycles), 32'd8);
        checkAllRowsZero("t4_fb");

        // po and clr together in IDLE: pixel wins, clear follows the triangle.
        applyStimulus(1, 3'd7, 3'd0, 0, 1);
        checkOutput("t5_collecting", 32'(collecting), 32'd1);
        checkOutput("t5_not_clearing", 32'(clr_busy), 32'd0);
        applyStimulus(0, 3'd0, 3'd0, 0, 0);
        checkOutput("t5_done", 32'(done), 32'd1);
        checkSummary("t5", 7'd1, 7'd0, 3'd7, 3'd7, 3'd0, 3'd0);
        checkRow("t5_row0", 3'd0, 8'b1000_0000);
        applyStimulus(0, 3'd0, 3'd0, 0, 0);
        checkOutput("t5_clear_start", 32'(clr_busy), 32'd1);
        waitClear(clrCycles);
        checkOutput("t5_clr_cycles", 32'(clrCycles), 32'd8);
        checkAllRowsZero("t5_fb");

        // Reset after five pixels of an unfinished triangle.
        applyStimulus(1, 3'd0, 3'd0, 0, 0);
        applyStimulus(1, 3'd1, 3'd0, 1, 0);
        applyStimulus(1, 3'd2, 3'd0, 1, 0);
        applyStimulus(1, 3'd3, 3'd0, 1, 0);
        applyStimulus(1, 3'd3, 3'd0, 1, 0);
        checkOutput("t6_dup_within", 32'(dup_cnt), 32'd1);
        checkRow("t6_row0_pre", 3'd0, 8'b0000_1111);
        reset = 1'b1;
        applyStimulus(0, 3'd0, 3'd0, 1, 0);
        checkOutput("t6_collecting", 32'(collecting), 32'd0);
        checkOutput("t6_done", 32'(done), 32'd0);
        checkSummary("t6", 7'd0, 7'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        checkAllRowsZero("t6_fb");
        reset = 1'b0;
        applyStimulus(0, 3'd0, 3'd0, 0, 0);
        checkOutput("t6_no_done", 32'(done), 32'd0);
        checkOutput("t6_no_clear", 32'(clr_busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
